// File: rtl/msg_source_arbiter_pkg.sv
// Shared types and widths for the message-source arbiter.
package msg_source_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, OFFER = 2'd1, ACTIVE = 2'd2, GAP = 2'd3} state_t;
  localparam int SRC_W   = 4;
  localparam int MAX_SRC = 1 << SRC_W;
  localparam int WAIT_W  = 4;
  localparam int LEN_W   = 8;
endpackage

// File: rtl/msg_source_arbiter_if.sv
// Source-side request bus and sequencer-side grant handshake.
interface msg_source_arbiter_if import msg_source_arbiter_pkg::*; #(
  parameter int NUM_SOURCES = 8
);
  logic [NUM_SOURCES-1:0]       GOT_FULL_MSG;
  logic [NUM_SOURCES*LEN_W-1:0] MSG_LEN_BUS;
  logic [NUM_SOURCES-1:0]       SRC_ENABLE;
  logic [NUM_SOURCES-1:0]       HIGH_PRIO;
  logic                         FLAG_FULL;
  logic                         GRANT_ACK;
  logic                         MSG_DONE;
  logic                         GRANT_VALID;
  logic [SRC_W-1:0]             GRANT_SRC;
  logic [LEN_W-1:0]             GRANT_LEN;
  logic [NUM_SOURCES-1:0]       GRANT;
  logic [1:0]                   state_monitor;

  modport master (
    input  GOT_FULL_MSG, MSG_LEN_BUS, SRC_ENABLE, HIGH_PRIO, FLAG_FULL, GRANT_ACK, MSG_DONE,
    output GRANT_VALID, GRANT_SRC, GRANT_LEN, GRANT, state_monitor
  );
  modport slave (
    output GOT_FULL_MSG, MSG_LEN_BUS, SRC_ENABLE, HIGH_PRIO, FLAG_FULL, GRANT_ACK, MSG_DONE,
    input  GRANT_VALID, GRANT_SRC, GRANT_LEN, GRANT, state_monitor
  );
endinterface

// File: rtl/msg_source_arbiter_rr_picker.sv
// First set request strictly after ptr, wrapping at N-1 -> 0.
module rr_picker import msg_source_arbiter_pkg::*; #(
  parameter int N = 8
)(
  input  logic [N-1:0]     req,
  input  logic [SRC_W-1:0] ptr,
  output logic [SRC_W-1:0] idx,
  output logic             found
);
  logic [MAX_SRC-1:0] req_pad;
  assign req_pad = MAX_SRC'(req);

  always_comb begin
    int j;
    logic [SRC_W-1:0] jj;
    j = 0;
    jj = '0;
    found = 1'b0;
    idx = '0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      jj = SRC_W'(j);
      if (!found && req_pad[jj]) begin
        found = 1'b1;
        idx = jj;
      end
    end
  end
endmodule

// File: rtl/msg_source_arbiter.sv
// Picks one complete-message source (starved > high-prio > normal, each round-robin)
// and holds the grant until the write sequencer reports the message done.
module msg_source_arbiter import msg_source_arbiter_pkg::*; #(
  parameter int NUM_SOURCES  = 8,
  parameter int STARVE_LIMIT = 4,
  parameter int GAP_CYCLES   = 2
)(
  input logic CLK,
  input logic RST,
  msg_source_arbiter_if.master bus
);
  state_t state, nxt;
  logic [NUM_SOURCES-1:0]              eligible, starved, prio, grant;
  logic [MAX_SRC-1:0]                  elig_pad;
  logic [MAX_SRC-1:0][LEN_W-1:0]       len_arr;
  logic [NUM_SOURCES-1:0][WAIT_W-1:0]  wait_cnt;
  logic [SRC_W-1:0] rr_ptr, grant_src, win_src, s_idx, p_idx, e_idx;
  logic             s_fnd, p_fnd, any_elig, grant_valid, gap_last;
  logic [LEN_W-1:0] grant_len;
  logic [3:0]       gap_cnt;

  assign eligible = bus.GOT_FULL_MSG & bus.SRC_ENABLE;
  assign prio     = eligible & bus.HIGH_PRIO;
  assign elig_pad = MAX_SRC'(eligible);

  for (genvar i = 0; i < MAX_SRC; i++) begin : g_src
    if (i < NUM_SOURCES) begin : g_on
      assign len_arr[i] = bus.MSG_LEN_BUS[i*LEN_W +: LEN_W];
      assign starved[i] = eligible[i] && (wait_cnt[i] >= WAIT_W'(STARVE_LIMIT));
    end else begin : g_off
      assign len_arr[i] = '0;
    end
  end

  rr_picker #(.N(NUM_SOURCES)) u_pick_starved (.req(starved),  .ptr(rr_ptr), .idx(s_idx), .found(s_fnd));
  rr_picker #(.N(NUM_SOURCES)) u_pick_prio    (.req(prio),     .ptr(rr_ptr), .idx(p_idx), .found(p_fnd));
  rr_picker #(.N(NUM_SOURCES)) u_pick_normal  (.req(eligible), .ptr(rr_ptr), .idx(e_idx), .found(any_elig));

  assign win_src  = s_fnd ? s_idx : (p_fnd ? p_idx : e_idx);
  assign gap_last = (gap_cnt == 4'(GAP_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (!bus.FLAG_FULL && any_elig) nxt = OFFER;
      OFFER:   if (bus.GRANT_ACK) nxt = ACTIVE;
               else if (!elig_pad[grant_src]) nxt = IDLE;
      ACTIVE:  if (bus.MSG_DONE) nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:     if (gap_last) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      grant_valid <= 1'b0;
      grant_src   <= '0;
      grant_len   <= '0;
      grant       <= '0;
      rr_ptr      <= SRC_W'(NUM_SOURCES - 1);
      wait_cnt    <= '0;
      gap_cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (nxt == OFFER) begin
          grant_valid <= 1'b1;
          grant_src   <= win_src;
          grant_len   <= len_arr[win_src];
        end
        OFFER: if (bus.GRANT_ACK) begin
          grant_valid <= 1'b0;
          grant       <= NUM_SOURCES'(MAX_SRC'(1) << grant_src);
          rr_ptr      <= grant_src;
          // Pass-over counting uses eligibility seen at the accepted offer.
          for (int i = 0; i < NUM_SOURCES; i++) begin
            if (SRC_W'(i) == grant_src)  wait_cnt[i] <= '0;
            else if (eligible[i])        wait_cnt[i] <= (wait_cnt[i] == '1) ? wait_cnt[i] : wait_cnt[i] + 1'b1;
            else                         wait_cnt[i] <= '0;
          end
        end else if (nxt == IDLE) begin
          grant_valid <= 1'b0;
        end
        ACTIVE: if (bus.MSG_DONE) begin
          grant   <= '0;
          gap_cnt <= '0;
        end
        GAP:     gap_cnt <= gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.GRANT_VALID   = grant_valid;
  assign bus.GRANT_SRC     = grant_src;
  assign bus.GRANT_LEN     = grant_len;
  assign bus.GRANT         = grant;
  assign bus.state_monitor = state;
endmodule

// File: tb/tb_msg_source_arbiter.sv
// Randomized and directed check of msg_source_arbiter against a transaction-level model.
module tb_msg_source_arbiter;
  import msg_source_arbiter_pkg::*;
  localparam int NS = 8, SL = 4, GAPC = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  msg_source_arbiter_if #(.NUM_SOURCES(NS)) b0();
  msg_source_arbiter_if #(.NUM_SOURCES(NS)) b1();

  msg_source_arbiter #(.NUM_SOURCES(NS), .STARVE_LIMIT(SL), .GAP_CYCLES(GAPC)) u_dut (
    .CLK(CLK), .RST(RST), .bus(b0.master));
  msg_source_arbiter #(.NUM_SOURCES(NS), .STARVE_LIMIT(SL), .GAP_CYCLES(0)) u_gap0 (
    .CLK(CLK), .RST(RST), .bus(b1.master));

  assign b1.GOT_FULL_MSG = b0.GOT_FULL_MSG;
  assign b1.MSG_LEN_BUS  = b0.MSG_LEN_BUS;
  assign b1.SRC_ENABLE   = b0.SRC_ENABLE;
  assign b1.HIGH_PRIO    = b0.HIGH_PRIO;
  assign b1.FLAG_FULL    = b0.FLAG_FULL;
  assign b1.GRANT_ACK    = b0.GRANT_ACK;
  assign b1.MSG_DONE     = b0.MSG_DONE;

  int n_vec = 0, n_err = 0;
  int m_wait [NS];
  int m_ptr;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  function automatic int msg_len(input int s);
    return int'(b0.MSG_LEN_BUS[s*8 +: 8]);
  endfunction

  function automatic bit is_elig(input int s);
    return b0.GOT_FULL_MSG[s] && b0.SRC_ENABLE[s];
  endfunction

  // Class 3 starved, 2 high-prio, 1 plain eligible; first in rotation order wins within a class.
  function automatic int model_pick();
    int best, best_cls, j, cls;
    best = -1; best_cls = 0;
    for (int k = 1; k <= NS; k++) begin
      j = (m_ptr + k) % NS;
      if (!is_elig(j))           cls = 0;
      else if (m_wait[j] >= SL)  cls = 3;
      else if (b0.HIGH_PRIO[j])  cls = 2;
      else                       cls = 1;
      if (cls > best_cls) begin best = j; best_cls = cls; end
    end
    return best;
  endfunction

  task automatic model_ack(input int src);
    for (int i = 0; i < NS; i++) begin
      if (i == src)        m_wait[i] = 0;
      else if (is_elig(i)) m_wait[i] = (m_wait[i] >= 15) ? 15 : m_wait[i] + 1;
      else                 m_wait[i] = 0;
    end
    m_ptr = src;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    b0.GOT_FULL_MSG = '0; b0.MSG_LEN_BUS = '0; b0.SRC_ENABLE = '1; b0.HIGH_PRIO = '0;
    b0.FLAG_FULL = 1'b1; b0.GRANT_ACK = 1'b0; b0.MSG_DONE = 1'b0;
    tick(); tick();
    RST = 1'b0;
    for (int i = 0; i < NS; i++) m_wait[i] = 0;
    m_ptr = NS - 1;
  endtask

  // Releases FLAG_FULL for one cycle from IDLE and checks the offer that follows.
  task automatic offer(input int exp_src, output int src);
    int w;
    w = model_pick();
    b0.FLAG_FULL = 1'b0;
    tick();
    b0.FLAG_FULL = 1'b1;
    src = w;
    if (w < 0) begin
      chk("no_offer", b0.GRANT_VALID, 0);
      return;
    end
    chk("offer_valid", b0.GRANT_VALID, 1);
    chk("offer_src", b0.GRANT_SRC, w);
    chk("offer_len", b0.GRANT_LEN, msg_len(w));
    if (exp_src >= 0) chk("offer_order", b0.GRANT_SRC, exp_src);
  endtask

  task automatic ack(input int src, input int hold, input bit drop, input bit toggle);
    b0.GRANT_ACK = 1'b1;
    if (drop) b0.GOT_FULL_MSG[src] = 1'b0;
    model_ack(src);
    tick();
    b0.GRANT_ACK = 1'b0;
    chk("grant_onehot", b0.GRANT, 1 << src);
    chk("valid_clr", b0.GRANT_VALID, 0);
    chk("state_active", b0.state_monitor, 2);
    repeat (hold) begin
      if (toggle) b0.GOT_FULL_MSG = 8'($urandom);
      tick();
      chk("grant_held", b0.GRANT, 1 << src);
    end
  endtask

  task automatic done_msg();
    b0.MSG_DONE = 1'b1;
    tick();
    b0.MSG_DONE = 1'b0;
    chk("grant_clr", b0.GRANT, 0);
    repeat (GAPC) tick();
    chk("back_idle", b0.state_monitor, 0);
  endtask

  task automatic run_msg(input int exp_src);
    int s;
    offer(exp_src, s);
    if (s >= 0) begin
      ack(s, 4, 1'b0, 1'b0);
      done_msg();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int s, v0, v1, mode;

    do_reset();
    chk("rst_valid", b0.GRANT_VALID, 0);
    chk("rst_grant", b0.GRANT, 0);
    chk("rst_src", b0.GRANT_SRC, 0);
    chk("rst_len", b0.GRANT_LEN, 0);
    chk("rst_state", b0.state_monitor, 0);

    // Gap latency on both gap settings, run in lockstep.
    b0.GOT_FULL_MSG = 8'h01;
    b0.MSG_LEN_BUS[7:0] = 8'd0;
    offer(0, s);
    ack(0, 2, 1'b0, 1'b0);
    b0.FLAG_FULL = 1'b0;
    b0.MSG_DONE = 1'b1;
    tick();
    b0.MSG_DONE = 1'b0;
    v0 = -1; v1 = -1;
    for (int c = 1; c <= 12; c++) begin
      if (b0.GRANT_VALID && v0 < 0) v0 = c;
      if (b1.GRANT_VALID && v1 < 0) v1 = c;
      if (v0 >= 0 && v1 >= 0) break;
      tick();
    end
    chk("gap2_latency", v0, GAPC + 2);
    chk("gap0_latency", v1, 2);
    chk("gap_reoffer_src", b0.GRANT_SRC, 0);

    // Plain round-robin between two sources, plus FLAG_FULL blocking.
    do_reset();
    b0.GOT_FULL_MSG = 8'b0000_0110;
    for (int i = 0; i < NS; i++) b0.MSG_LEN_BUS[i*8 +: 8] = 8'(10 + i);
    repeat (3) begin
      tick();
      chk("full_blocks", b0.GRANT_VALID, 0);
    end
    run_msg(1); run_msg(2); run_msg(1); run_msg(2);

    // Static priority with starvation promotion of source 0.
    do_reset();
    b0.HIGH_PRIO = 8'h80;
    b0.GOT_FULL_MSG = 8'h81;
    run_msg(7); run_msg(7); run_msg(7); run_msg(7); run_msg(0); run_msg(7);

    // Withdrawal leaves the pointer alone.
    do_reset();
    b0.GOT_FULL_MSG = 8'h18;
    b0.MSG_LEN_BUS[31:24] = 8'd200;
    offer(3, s);
    chk("len_200", b0.GRANT_LEN, 200);
    b0.GOT_FULL_MSG[3] = 1'b0;
    tick();
    chk("withdraw_valid", b0.GRANT_VALID, 0);
    chk("withdraw_state", b0.state_monitor, 0);
    b0.GOT_FULL_MSG = 8'h18;
    offer(3, s);

    // ACK and MSG_DONE outside their states are ignored.
    do_reset();
    b0.GOT_FULL_MSG = 8'h01;
    b0.GRANT_ACK = 1'b1; b0.MSG_DONE = 1'b1;
    tick();
    b0.GRANT_ACK = 1'b0; b0.MSG_DONE = 1'b0;
    chk("stray_state", b0.state_monitor, 0);
    chk("stray_grant", b0.GRANT, 0);

    // Reset while active drops the grant.
    do_reset();
    b0.GOT_FULL_MSG = 8'h20;
    b0.MSG_LEN_BUS[47:40] = 8'd33;
    offer(5, s);
    ack(5, 2, 1'b0, 1'b0);
    b0.GOT_FULL_MSG = 8'h24;
    RST = 1'b1;
    tick();
    chk("midrst_grant", b0.GRANT, 0);
    chk("midrst_valid", b0.GRANT_VALID, 0);
    chk("midrst_src", b0.GRANT_SRC, 0);
    chk("midrst_len", b0.GRANT_LEN, 0);
    chk("midrst_state", b0.state_monitor, 0);
    RST = 1'b0;
    for (int i = 0; i < NS; i++) m_wait[i] = 0;
    m_ptr = NS - 1;
    offer(2, s);

    // Randomized traffic.
    do_reset();
    for (int it = 0; it < 80; it++) begin
      b0.GOT_FULL_MSG = 8'($urandom);
      b0.SRC_ENABLE   = 8'($urandom) | 8'($urandom);
      b0.HIGH_PRIO    = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      b0.MSG_LEN_BUS  = {$urandom, $urandom};
      tick();
      offer(-1, s);
      if (s >= 0) begin
        mode = $urandom_range(0, 3);
        repeat ($urandom_range(0, 2)) begin
          tick();
          chk("offer_stable", b0.GRANT_SRC, s);
        end
        if (mode == 0) begin
          b0.GOT_FULL_MSG[s] = 1'b0;
          tick();
          chk("rnd_withdraw", b0.GRANT_VALID, 0);
          chk("rnd_withdraw_st", b0.state_monitor, 0);
        end else begin
          ack(s, $urandom_range(1, 5), mode == 1, 1'b1);
          done_msg();
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/msg_source_arbiter.md
# msg_source_arbiter

Arbitrates among the per-source message FIFOs that compete for the USB Slave-FIFO write path. It picks one source with a complete message using round-robin, a static high-priority mask and starvation promotion, then hands source index and message length to the Slave-FIFO write sequencer. It holds the grant until that sequencer reports the message finished. It sits between the per-source `GOT_FULL_MSG`/`MSG_LEN_BUS` producers and the write sequencer, replacing the free-running source counter.

## Interface
- `NUM_SOURCES`, 8: number of requesters, 1..16.
- `STARVE_LIMIT`, 4: accepted grants a waiting source may be passed over before promotion, 1..15.
- `GAP_CYCLES`, 2: idle cycles inserted after each message, 0..15.

- `CLK` in 1: the single clock.
- `RST` in 1: reset, synchronous and active-high.
- `GOT_FULL_MSG` in NUM_SOURCES: source i holds a complete message.
- `MSG_LEN_BUS` in NUM_SOURCES*8: payload length of source i in bits [8i+7:8i], in words.
- `SRC_ENABLE` in NUM_SOURCES: per-source enable mask.
- `HIGH_PRIO` in NUM_SOURCES: static priority mask.
- `FLAG_FULL` in 1: Slave-FIFO full flag, high = full.
- `GRANT_ACK` in 1: write sequencer accepts the offered grant.
- `MSG_DONE` in 1: one-cycle pulse, granted message fully written.
- `GRANT_VALID` out 1: offer pending.
- `GRANT_SRC` out 4: granted source index.
- `GRANT_LEN` out 8: length captured at offer time.
- `GRANT` out NUM_SOURCES: one-hot, active source during transfer.
- `state_monitor` out 2: current state.

## Operation
- eligible[i] = `GOT_FULL_MSG`[i] & `SRC_ENABLE`[i].
- starved[i] = eligible[i] & (wait_cnt[i] >= `STARVE_LIMIT`).
- Winner selection:
  - If any source is starved, pick round-robin among starved sources.
  - Else if any source is eligible and in `HIGH_PRIO`, pick round-robin among those.
  - Else pick round-robin among eligible sources.
- Round-robin search starts at rr_ptr+1 and wraps at NUM_SOURCES-1 → 0.
- States: IDLE=0, OFFER=1, ACTIVE=2, GAP=3.
  - IDLE:
    - Advances only if `FLAG_FULL`=0 and any source is eligible.
    - Registers the winner into `GRANT_SRC`, `MSG_LEN`[winner] into `GRANT_LEN`, sets `GRANT_VALID`=1 → OFFER.
  - OFFER:
    - `GRANT_SRC`/`GRANT_LEN` stay stable until acknowledged.
    - On `GRANT_ACK`: `GRANT_VALID`=0, `GRANT`=onehot(`GRANT_SRC`), rr_ptr=`GRANT_SRC`, wait counters updated → ACTIVE.
    - If the winner loses eligibility before `GRANT_ACK`: withdraw (`GRANT_VALID`=0), no pointer or counter update → IDLE.
    - `GRANT_ACK` and loss of eligibility in the same cycle: ACK wins.
  - ACTIVE:
    - `GRANT` is held, independent of `GOT_FULL_MSG` and `FLAG_FULL`.
    - On `MSG_DONE`: `GRANT`=0 → GAP, or → IDLE if `GAP_CYCLES`=0.
  - GAP: counts `GAP_CYCLES` cycles, then → IDLE.
- Wait counters (4 bit, saturate at 15) update only on `GRANT_ACK`:
  - Granted source cleared.
  - Other eligible sources incremented.
  - Non-eligible sources cleared.
- `GRANT_LEN` = 0 is legal and passed through unchanged.
- `MSG_DONE` outside ACTIVE and `GRANT_ACK` outside OFFER are ignored.

## Timing
- Reset values:
  - State IDLE.
  - `GRANT_VALID`=0, `GRANT`=0, `GRANT_SRC`=0, `GRANT_LEN`=0, `state_monitor`=0.
  - All wait counters 0; gap counter 0.
  - rr_ptr=NUM_SOURCES-1, so source 0 wins first.
- Latency: eligible and not full in IDLE at cycle t → `GRANT_VALID`=1 at t+1.
- `GRANT_ACK` at t → `GRANT` one-hot at t+1.
- `MSG_DONE` at t → `GRANT`=0 at t+1; next `GRANT_VALID` no earlier than t+2+`GAP_CYCLES`.
- All outputs are registered; no combinational input→output path.
- `RST` mid-transfer: everything returns to reset values on the next edge, including a dropped grant.

## Structure
- Shared package holds:
  - State encodings IDLE/OFFER/ACTIVE/GAP.
  - `SRC_W`=4, matching the 4-bit source field in the message header.
  - Wait-counter width.
- Sub-module `rr_picker`: given a request vector and a pointer, returns the first set index after the pointer with wrap, plus a found flag. Instantiated three times (starved, priority, normal) with a final priority mux.

## Test plan
- Reset, then `GOT_FULL_MSG`=8'b0000_0110, ACK every offer, `MSG_DONE` 5 cycles after each ACK, requests kept high → grant order 1,2,1,2; `GRANT_VALID` one cycle after IDLE.
- `HIGH_PRIO`=8'h80, requests 8'h81, `STARVE_LIMIT`=4 → grants 7,7,7,7,0,7 (source 0 promoted after 4 pass-overs).
- Offer source 3 with `MSG_LEN`[3]=200, drop `GOT_FULL_MSG`[3] before ACK → `GRANT_VALID`=0 next cycle, state IDLE, rr_ptr unchanged (next winner still searched from old pointer).
- `FLAG_FULL`=1 with requests pending → no offer; deassert → `GRANT_VALID`=1 one cycle later.
- `GAP_CYCLES`=2: `MSG_DONE` at t → `GRANT_VALID` at t+4; repeat with `GAP_CYCLES`=0 → t+2.
- Assert `RST` while ACTIVE on source 5 → next cycle all outputs 0; first grant after release goes to the lowest eligible index.
